// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response port between the fetch stage and memory.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (output req, addr, input  rvalid, rdata);
    modport slave  (input  req, addr, output rvalid, rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one instruction per request and picks the
// next PC from the execute path's branch/jump/halt outcome.
//
// state    | meaning
// IDLE     | post-reset cycle, no request yet
// REQ      | imem_req asserted for one cycle at pc
// WAIT     | waiting for the response, timeout counter running
// VALID    | instr/pc presented to decode until ex_done
// HALTED   | halt executed or fault; left only by rst
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       TIMEOUT  = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_unit_if.master   imem,
    input  logic                 ex_done,
    input  logic                 take_branch,
    input  logic                 alu_to_pc,
    input  logic                 halt,
    input  logic [ADDR_W-1:0]    imm,
    input  logic [ADDR_W-1:0]    alu_result,
    output logic [31:0]          instr,
    output logic [6:0]           opcode,
    output logic [4:0]           rd,
    output logic [2:0]           func3,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [6:0]           func7,
    output logic [ADDR_W-1:0]    pc,
    output logic [ADDR_W-1:0]    pc_plus4,
    output logic                 instr_valid,
    output logic                 halted,
    output logic                 fetch_fault
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_VALID,
        S_HALTED
    } state_t;

    localparam logic [16:0]       TIMEOUT_TC = 17'(TIMEOUT);
    localparam logic [ADDR_W-1:0] JALR_MASK  = {{(ADDR_W-1){1'b1}}, 1'b0};
    localparam logic [ADDR_W-1:0] FOUR       = {{(ADDR_W-3){1'b0}}, 3'd4};

    state_t            state;
    logic              req;
    logic [15:0]       wait_cnt;
    logic [16:0]       wait_next;
    logic [ADDR_W-1:0] target;

    assign imem.req  = req;
    assign imem.addr = pc;

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign func3    = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign func7    = instr[31:25];
    assign pc_plus4 = pc + FOUR;

    assign wait_next = {1'b0, wait_cnt} + 17'd1;

    always_comb begin
        target = pc_plus4;
        if (alu_to_pc) begin
            target = alu_result & JALR_MASK;
        end else if (take_branch) begin
            target = pc + imm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            req         <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_fault <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    req   <= 1'b1;
                    state <= S_REQ;
                end
                S_REQ: begin
                    req      <= 1'b0;
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem.rvalid) begin
                        instr       <= imem.rdata;
                        instr_valid <= 1'b1;
                        state       <= S_VALID;
                    end else if (wait_next == TIMEOUT_TC) begin
                        fetch_fault <= 1'b1;
                        halted      <= 1'b1;
                        state       <= S_HALTED;
                    end else begin
                        wait_cnt <= wait_next[15:0];
                    end
                end
                S_VALID: begin
                    if (ex_done) begin
                        instr_valid <= 1'b0;
                        if (halt) begin
                            halted <= 1'b1;
                            state  <= S_HALTED;
                        end else begin
                            pc <= target;
                            // bit 1 set means the target is not word aligned
                            if (target[1]) begin
                                fetch_fault <= 1'b1;
                                halted      <= 1'b1;
                                state       <= S_HALTED;
                            end else begin
                                req   <= 1'b1;
                                state <= S_REQ;
                            end
                        end
                    end
                end
                S_HALTED: begin
                    req <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_instr_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h100;
    localparam int          TOUT   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_done = 1'b0, take_branch = 1'b0, alu_to_pc = 1'b0, halt = 1'b0;
    logic [31:0] imm = '0, alu_result = '0;

    logic [31:0] instr, pc, pc_plus4;
    logic [6:0]  opcode, func7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  func3;
    logic        instr_valid, halted, fetch_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(32)) imem ();

    instr_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (RST_PC),
        .TIMEOUT  (TOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem),
        .ex_done     (ex_done),
        .take_branch (take_branch),
        .alu_to_pc   (alu_to_pc),
        .halt        (halt),
        .imm         (imm),
        .alu_result  (alu_result),
        .instr       (instr),
        .opcode      (opcode),
        .rd          (rd),
        .func3       (func3),
        .rs1         (rs1),
        .rs2         (rs2),
        .func7       (func7),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr_valid (instr_valid),
        .halted      (halted),
        .fetch_fault (fetch_fault)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h4000_0033;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory: answers a request after mem_lat cycles (0 = never), drops on rst.
    int          mem_lat  = 1;
    bit          mem_rand = 1'b0;
    bit          force_rv = 1'b0;
    int          cd       = 0;
    logic [31:0] pend_addr = '0;

    initial begin
        imem.rvalid = 1'b0;
        imem.rdata  = '0;
        forever begin
            @(negedge clk);
            #1;
            imem.rvalid = 1'b0;
            imem.rdata  = $urandom;
            if (rst) begin
                cd = 0;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    imem.rvalid = 1'b1;
                    imem.rdata  = mem_word(pend_addr);
                end
            end
            if (!rst && imem.req) begin
                pend_addr = imem.addr;
                cd = mem_rand ? $urandom_range(1, 3) : mem_lat;
            end
            if (force_rv) begin
                imem.rvalid = 1'b1;
                imem.rdata  = 32'hDEAD_BEEF;
            end
        end
    end

    // Reference model: what has been fetched, what is pending, where the PC is.
    bit          m_on = 1'b0;
    logic [31:0] m_pc, m_instr, t;
    bit          m_valid, m_halted, m_fault, m_req, m_boot, m_waiting, nreq;
    int          m_wait;
    logic [31:0] req_log[$];

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_on = 1'b1; m_pc = RST_PC; m_instr = '0; m_valid = 1'b0;
                m_halted = 1'b0; m_fault = 1'b0; m_req = 1'b0; m_boot = 1'b1;
                m_waiting = 1'b0; m_wait = 0;
            end else if (m_on && !m_halted) begin
                nreq = 1'b0;
                if (m_boot) begin
                    m_boot = 1'b0;
                    nreq = 1'b1;
                end else if (m_req) begin
                    m_waiting = 1'b1;
                    m_wait = 0;
                end else if (m_waiting) begin
                    if (imem.rvalid) begin
                        m_instr = imem.rdata;
                        m_valid = 1'b1;
                        m_waiting = 1'b0;
                    end else begin
                        m_wait++;
                        if (m_wait >= TOUT) begin
                            m_fault = 1'b1; m_halted = 1'b1; m_waiting = 1'b0;
                        end
                    end
                end else if (m_valid && ex_done) begin
                    m_valid = 1'b0;
                    if (halt) begin
                        m_halted = 1'b1;
                    end else begin
                        if (alu_to_pc)        t = alu_result - (alu_result % 2);
                        else if (take_branch) t = m_pc + imm;
                        else                  t = m_pc + 32'd4;
                        m_pc = t;
                        if ((t / 2) % 2 == 1) begin
                            m_fault = 1'b1; m_halted = 1'b1;
                        end else begin
                            nreq = 1'b1;
                        end
                    end
                end
                m_req = nreq;
            end
            #1;
            if (m_on) begin
                if (imem.req) req_log.push_back(imem.addr);
                chk("req", 32'(imem.req), 32'(m_req));
                chk("imem_addr", imem.addr, m_pc);
                chk("pc", pc, m_pc);
                chk("pc_plus4", pc_plus4, m_pc + 32'd4);
                chk("instr_valid", 32'(instr_valid), 32'(m_valid));
                chk("halted", 32'(halted), 32'(m_halted));
                chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
                chk("instr", instr, m_instr);
                if (m_valid) begin
                    chk("opcode", 32'(opcode), m_instr % 128);
                    chk("rd", 32'(rd), (m_instr >> 7) % 32);
                    chk("func3", 32'(func3), (m_instr >> 12) % 8);
                    chk("rs1", 32'(rs1), (m_instr >> 15) % 32);
                    chk("rs2", 32'(rs2), (m_instr >> 20) % 32);
                    chk("func7", 32'(func7), m_instr >> 25);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        ex_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!instr_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!instr_valid) chk(nm, 32'(instr_valid), 32'd1);
    endtask

    task automatic exec(input logic h, input logic a, input logic b,
                        input logic [31:0] im, input logic [31:0] ar);
        wait_valid("exec_wait_valid");
        ex_done = 1'b1; halt = h; alu_to_pc = a; take_branch = b;
        imm = im; alu_result = ar;
        @(negedge clk);
        ex_done = 1'b0; halt = 1'b0; alu_to_pc = 1'b0; take_branch = 1'b0;
    endtask

    logic [31:0] exp_addr [7];

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_addr = '{32'h100, 32'h104, 32'h108, 32'h100, 32'h200, 32'hFFFF_FFFC, 32'h0};

        // Reset, first fetch timing and sequential/branch/JALR/wrap/misaligned flow
        mem_lat = 1;
        @(negedge clk);
        do_reset();
        req_log.delete();
        @(posedge clk); #2;
        chk("first_req", 32'(imem.req), 32'd1);
        chk("first_addr", imem.addr, 32'h100);
        @(posedge clk); #2;
        chk("wait_not_valid", 32'(instr_valid), 32'd0);
        @(posedge clk); #2;
        chk("valid_cycle3", 32'(instr_valid), 32'd1);
        chk("first_opcode", 32'(opcode), 32'h33);
        chk("first_func7", 32'(func7), 32'h20);
        chk("first_pc_plus4", pc_plus4, 32'h104);
        @(negedge clk);
        exec(0, 0, 0, 32'h0, 32'h0);
        exec(0, 0, 0, 32'h0, 32'h0);
        exec(0, 0, 1, 32'hFFFF_FFF8, 32'h0);
        exec(0, 1, 0, 32'h0, 32'h201);
        exec(0, 1, 0, 32'h0, 32'hFFFF_FFFD);
        exec(0, 0, 0, 32'h0, 32'h0);
        exec(0, 1, 0, 32'h0, 32'h202);
        repeat (2) @(negedge clk);
        chk("jalr_fault", 32'(fetch_fault), 32'd1);
        chk("jalr_halted", 32'(halted), 32'd1);
        chk("jalr_pc", pc, 32'h202);
        repeat (6) @(negedge clk);
        chk("req_count", 32'(req_log.size()), 32'd7);
        for (int i = 0; i < 7 && i < req_log.size(); i++) chk("req_addr", req_log[i], exp_addr[i]);

        // Halt holds pc and ignores late responses
        do_reset();
        exec(1, 0, 0, 32'h0, 32'h0);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_no_fault", 32'(fetch_fault), 32'd0);
        chk("halt_pc", pc, 32'h100);
        force_rv = 1'b1;
        @(negedge clk);
        force_rv = 1'b0;
        @(negedge clk);
        chk("halt_instr_kept", instr, 32'h4000_0033);
        chk("halt_not_valid", 32'(instr_valid), 32'd0);
        do_reset();
        @(posedge clk); #2;
        chk("rst_refetch_req", 32'(imem.req), 32'd1);
        chk("rst_refetch_addr", imem.addr, 32'h100);

        // Timeout with no response
        @(negedge clk);
        mem_lat = 0;
        do_reset();
        repeat (5) @(posedge clk);
        #2;
        chk("tout_not_early", 32'(fetch_fault), 32'd0);
        @(posedge clk); #2;
        chk("tout_fault", 32'(fetch_fault), 32'd1);
        chk("tout_halted", 32'(halted), 32'd1);

        // Reset in the middle of WAIT, stale response afterwards
        @(negedge clk);
        mem_lat = 2;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        force_rv = 1'b1;
        @(negedge clk);
        force_rv = 1'b0;
        mem_lat = 1;
        chk("midwait_not_valid", 32'(instr_valid), 32'd0);
        chk("midwait_instr", instr, 32'h0);
        chk("midwait_refetch", 32'(imem.req), 32'd1);
        wait_valid("midwait_wait_valid");
        chk("midwait_new_instr", instr, 32'h4000_0033);

        // Randomized traffic
        mem_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = ((m_halted && ($urandom % 4 == 0)) || ($urandom % 300 == 0));
            ex_done     = ($urandom % 3 == 0);
            halt        = ($urandom % 20 == 0);
            alu_to_pc   = ($urandom % 5 == 0);
            take_branch = ($urandom % 3 == 0);
            imm = ($urandom_range(0, 64) << 2) - 32'd128;
            if ($urandom % 16 == 0) imm = imm | 32'h2;
            case ($urandom % 10)
                0:       alu_result = 32'hFFFF_FFFD;
                1:       alu_result = ($urandom & 32'hFFFC) | 32'h2;
                default: alu_result = ($urandom & 32'hFFFC) | ($urandom & 32'h1);
            endcase
        end
        @(negedge clk);
        rst = 1'b0;
        ex_done = 1'b0;
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Instruction-fetch stage directly upstream of the single-cycle decoder/control logic.
- Owns the program counter and fetches one 32-bit instruction at a time over a request/response instruction-memory port.
- Presents the decoded fields (opcode, func3, func7, register indices) plus pc/pc+4 to the decode/execute path.
- Computes the next PC from the control unit's branch/jump/halt outcome once the execute path signals completion.

## Interface
- `ADDR_W`, default 32: PC and instruction-address width.
- `RESET_PC`, default 0: PC value loaded on reset; must be 4-byte aligned.
- `TIMEOUT`, default 255: maximum cycles spent in WAIT before a fetch fault; range 1..65535.
- `clk` in, 1: single clock; all state changes on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `imem_req` out, 1: one-cycle fetch request.
- `imem_addr` out, ADDR_W: fetch address; equals `pc`.
- `imem_rvalid` in, 1: response valid.
- `imem_rdata` in, 32: instruction word.
- `ex_done` in, 1: execute path has finished the instruction currently presented.
- `take_branch` in, 1: redirect to `pc + imm`. Already resolved as BR AND (JAL OR branch condition).
- `alu_to_pc` in, 1: redirect to ALU result (JALR).
- `halt` in, 1: the current instruction is halt.
- `imm` in, ADDR_W: sign-extended branch/JAL offset.
- `alu_result` in, ADDR_W: JALR target.
- `instr` out, 32: latched instruction.
- `opcode` out, 7: `instr[6:0]`.
- `rd` out, 5: `instr[11:7]`.
- `func3` out, 3: `instr[14:12]`.
- `rs1` out, 5: `instr[19:15]`.
- `rs2` out, 5: `instr[24:20]`.
- `func7` out, 7: `instr[31:25]`.
- `pc` out, ADDR_W: address of `instr`.
- `pc_plus4` out, ADDR_W: `pc + 4`, for the PCToReg path.
- `instr_valid` out, 1: `instr` and `pc` are valid for execution.
- `halted` out, 1: halt executed, or fault.
- `fetch_fault` out, 1: misaligned target or WAIT timeout.

## Operation
- States: IDLE, REQ, WAIT, VALID, HALTED.
- Reset:
  - `pc` = `RESET_PC`, `instr` = 0, state = IDLE.
  - `imem_req`, `instr_valid`, `halted`, `fetch_fault` are all 0; timeout counter is 0.
- IDLE -> REQ unconditionally.
- REQ:
  - `imem_req` = 1 for exactly this cycle; `imem_addr` = `pc`.
  - Next state is WAIT; counter is cleared.
  - `imem_rvalid` is ignored in REQ.
- WAIT:
  - On `imem_rvalid`, latch `imem_rdata` into `instr` and go to VALID.
  - Otherwise the counter increments. Reaching `TIMEOUT` sets `fetch_fault` = 1 and goes to HALTED.
- VALID:
  - `instr_valid` = 1; `instr` and `pc` hold stable.
  - Holds until `ex_done`. On `ex_done`, the next PC is chosen in priority order:
    1. `halt`: pc holds, go to HALTED.
    2. `alu_to_pc`: {`alu_result`[ADDR_W-1:1], 1'b0}.
    3. `take_branch`: `pc + imm`.
    4. Otherwise `pc + 4`.
  - If the selected target has bit 1 set: pc still loads the target, `fetch_fault` = 1, go to HALTED.
  - Otherwise load pc and go to REQ.
- HALTED:
  - `halted` = 1, `instr_valid` = 0, no requests issued.
  - Left only by `rst`.
- Arithmetic: all PC sums are modulo 2^ADDR_W; e.g. 0xFFFFFFFC + 4 = 0.
- `imem_rvalid` outside WAIT is ignored; `ex_done` outside VALID is ignored.
- `rst` in any state, including mid-WAIT, wins. A response arriving after reset is ignored unless the block is again in WAIT. The instruction memory shares `rst` and drops outstanding requests.

## Timing
- Fetch latency: cycles from REQ to `instr_valid` = 1 + memory latency. With a next-cycle response, `instr_valid` rises 2 cycles after REQ.
- First `instr_valid` after reset release: cycle 3 with a next-cycle memory response.
- Decode outputs are combinational from the `instr` register and are stable for the whole VALID interval.
- `pc` updates on the `ex_done` edge; `instr_valid` falls that same edge.
- Steady-state throughput: one instruction per 3 cycles with a 1-cycle memory response.
- `halted` and `fetch_fault` rise on the edge leaving VALID or WAIT.

## Test plan
- Reset with `RESET_PC`=0x100, memory responds after 1 cycle:
  - `imem_req` is seen with addr 0x100.
  - `instr_valid` is seen with opcode 0x33 and func7 0x20.
  - `pc_plus4` = 0x104.
- Sequential execution: 3 instructions, each acknowledged with `ex_done` while `take_branch` = `alu_to_pc` = 0 -> fetch addresses are 0x100, 0x104, 0x108.
- Branch taken: at pc 0x108, `take_branch` = 1, `imm` = 0xFFFFFFF8 -> next fetch at 0x100.
- JALR: `alu_to_pc` = 1 with `alu_result` = 0x201 -> next fetch at 0x200 (bit 0 cleared).
- Misaligned JALR: `alu_result` = 0x202 -> `fetch_fault` = 1, `halted` = 1, no further `imem_req`.
- Halt: `halt` = 1 with `ex_done` -> `halted` = 1, pc holds; a later `imem_rvalid` has no effect. Reset returns the block to fetch at `RESET_PC`.
- Timeout: with `TIMEOUT` = 4 and no response, `fetch_fault` rises on the 4th WAIT cycle.
- Reset mid-WAIT: `rst` asserted mid-WAIT -> state is IDLE, `instr_valid` = 0, no stale latch.
